// File: rtl/rz_uart_pkg.sv
// ----------------------------------------------------------------------------
// rz_uart_pkg
// Shared definitions for the RZ-UART transmit and receive paths.
//   RZ_START_BIT / RZ_STOP_BIT : frame delimiters
//   rz_frame_len(dw)           : cycles per frame for a dw-bit payload
//   rz_tx_state_e              : serializer state values (IDLE, SHIFT, GAP)
// ----------------------------------------------------------------------------
package rz_uart_pkg;

    localparam logic RZ_START_BIT = 1'b0;
    localparam logic RZ_STOP_BIT  = 1'b1;

    function automatic int unsigned rz_frame_len(input int unsigned dw);
        return dw + 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } rz_tx_state_e;

endpackage

// File: rtl/rz_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// rz_sync_fifo
// Single-clock FIFO with first-word visibility on data_out (no fall-through
// into an empty FIFO). Pointers carry one extra MSB to tell full from empty.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   push, data_in     write request / word (ignored when full or flushing)
//   pop, data_out     read request (ignored when empty or flushing) / head word
//   flush             discard all stored words; wins over push and pop
//   full, empty       status
//   level             number of stored words, 0..DEPTH
// ----------------------------------------------------------------------------
module rz_sync_fifo
    import rz_uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               data_in,
    output logic [WIDTH-1:0]               data_out,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = LW'(wr_ptr - rd_ptr);
    assign data_out = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/rz_uart_tx.sv
// ----------------------------------------------------------------------------
// rz_uart_tx
// Buffered RZ-UART transmitter. Words arrive on a valid/ready stream, queue in
// rz_sync_fifo, and are serialized as start(0), data LSB first, stop(1), one
// bit per tx_clk cycle, with GAP_BITS idle cycles between frames.
// Ports:
//   tx_clk, reset_n   bit clock, async active-low reset
//   s_valid/s_ready   source handshake, s_data word (LSB sent first)
//   tx_enable         0 blocks the start of new frames (never truncates one)
//   flush             discard queued words; frame in flight completes
//   busy              frame in flight, gap running, or words queued
//   fifo_level        queued words, excluding the frame in flight
//   tx_p / tx_n       RZ pulses for logic 1 / logic 0 during tx_clk high
// ----------------------------------------------------------------------------
module rz_uart_tx
    import rz_uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_BITS   = 1
) (
    input  logic                              tx_clk,
    input  logic                              reset_n,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_WIDTH-1:0]             s_data,
    input  logic                              tx_enable,
    input  logic                              flush,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              tx_p,
    output logic                              tx_n
);

    localparam int unsigned FRAME_LEN = rz_frame_len(DATA_WIDTH);
    localparam int unsigned CW        = $clog2(FRAME_LEN);
    localparam int unsigned GW        = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_LEN - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP_BITS > 0) ? GW'(GAP_BITS - 1) : '0;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_GAP   = GAP;

    logic [1:0]            state;
    logic [FRAME_LEN-1:0]  shift;
    logic [CW-1:0]         cnt;
    logic [GW-1:0]         gcnt;
    logic                  tx_en;
    logic                  tx_bit;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  do_pop;

    assign s_ready = !fifo_full && !flush;

    rz_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (tx_clk),
        .reset_n  (reset_n),
        .push     (s_valid && s_ready),
        .pop      (do_pop),
        .flush    (flush),
        .data_in  (s_data),
        .data_out (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Pop points: IDLE, the stop-bit edge when no gap is configured, and the
    // last gap cycle. Popping on the last gap cycle keeps the idle time between
    // frames at exactly GAP_BITS cycles instead of GAP_BITS plus an IDLE cycle.
    always_comb begin
        do_pop = 1'b0;
        if (!flush && !fifo_empty && tx_enable) begin
            case (state)
                ST_IDLE:  do_pop = 1'b1;
                ST_SHIFT: do_pop = (cnt == '0) && (GAP_BITS == 0);
                ST_GAP:   do_pop = (gcnt == '0);
                default:  do_pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            shift  <= '0;
            cnt    <= '0;
            gcnt   <= '0;
            tx_en  <= 1'b0;
            tx_bit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_en  <= 1'b0;
                    tx_bit <= 1'b0;
                end
                ST_SHIFT: begin
                    tx_en  <= 1'b1;
                    tx_bit <= shift[0];
                    shift  <= shift >> 1;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (GAP_BITS > 0) begin
                        state <= ST_GAP;
                        gcnt  <= GAP_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    tx_en  <= 1'b0;
                    tx_bit <= 1'b0;
                    if (gcnt != '0) gcnt <= gcnt - 1'b1;
                    else            state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    tx_en <= 1'b0;
                end
            endcase
            // A pop overrides the state-local updates above with a fresh frame.
            if (do_pop) begin
                shift <= {RZ_STOP_BIT, fifo_data, RZ_START_BIT};
                cnt   <= CNT_LOAD;
                state <= ST_SHIFT;
            end
        end
    end

    assign busy = (state != ST_IDLE) || !fifo_empty;

    // tx_en/tx_bit only change on the rising edge, so gating with tx_clk
    // yields clean pulses confined to the high phase.
    assign tx_p = tx_en &  tx_bit & tx_clk;
    assign tx_n = tx_en & ~tx_bit & tx_clk;

endmodule

// File: tb/tb_rz_uart_tx.sv
module tb_rz_uart_tx;

    logic       tx_clk  = 1'b0;
    logic       reset_n = 1'b1;

    logic       s_valid = 1'b0, tx_enable = 1'b1, flush = 1'b0;
    logic [7:0] s_data  = '0;
    logic       s_ready, busy, tx_p, tx_n;
    logic [2:0] fifo_level;

    logic       g0_s_valid = 1'b0, g0_tx_enable = 1'b1, g0_flush = 1'b0;
    logic [7:0] g0_s_data  = '0;
    logic       g0_s_ready, g0_busy, g0_tx_p, g0_tx_n;
    logic [2:0] g0_fifo_level;

    rz_uart_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .GAP_BITS(1)) dut (
        .tx_clk(tx_clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .tx_enable(tx_enable), .flush(flush), .busy(busy),
        .fifo_level(fifo_level), .tx_p(tx_p), .tx_n(tx_n));

    rz_uart_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .GAP_BITS(0)) dut_g0 (
        .tx_clk(tx_clk), .reset_n(reset_n), .s_valid(g0_s_valid), .s_ready(g0_s_ready),
        .s_data(g0_s_data), .tx_enable(g0_tx_enable), .flush(g0_flush), .busy(g0_busy),
        .fifo_level(g0_fifo_level), .tx_p(g0_tx_p), .tx_n(g0_tx_n));

    always #5 tx_clk = ~tx_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge tx_clk) cyc <= cyc + 1;

    // Line receiver model: decodes frames from the pulse pair, one symbol per
    // cycle while tx_clk is high. Index 0 = GAP_BITS=1 DUT, 1 = GAP_BITS=0 DUT.
    int         in_frame [2] = '{0, 0};
    int         bitcnt   [2] = '{0, 0};
    int         fstart   [2] = '{0, 0};
    int         last_stop[2] = '{-100, -100};
    int         pulses   [2] = '{0, 0};
    int         frame_err = 0;
    logic [7:0] sh [2];
    logic       sp, sn;
    logic [7:0] qw0[$], qw1[$];
    int         qs0[$], qs1[$], qg0[$], qg1[$];

    always begin
        @(posedge tx_clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            sp = (m == 0) ? tx_p : g0_tx_p;
            sn = (m == 0) ? tx_n : g0_tx_n;
            if (!reset_n) begin
                in_frame[m] = 0;
            end else begin
                if (sp || sn) pulses[m]++;
                if (sp && sn) frame_err++;
                if (in_frame[m] == 0) begin
                    if (sn) begin
                        in_frame[m] = 1;
                        bitcnt[m]   = 0;
                        fstart[m]   = cyc;
                    end else if (sp) begin
                        frame_err++;
                    end
                end else if (bitcnt[m] < 8) begin
                    if (sp || sn) begin
                        sh[m][bitcnt[m]] = sp;
                        bitcnt[m]++;
                    end else begin
                        frame_err++;
                        in_frame[m] = 0;
                    end
                end else begin
                    if (sp) begin
                        if (m == 0) begin
                            qw0.push_back(sh[m]); qs0.push_back(fstart[m]);
                            qg0.push_back(fstart[m] - last_stop[m] - 1);
                        end else begin
                            qw1.push_back(sh[m]); qs1.push_back(fstart[m]);
                            qg1.push_back(fstart[m] - last_stop[m] - 1);
                        end
                        last_stop[m] = cyc;
                    end else begin
                        frame_err++;
                    end
                    in_frame[m] = 0;
                end
            end
        end
    end

    task automatic clear_queues();
        qw0.delete(); qs0.delete(); qg0.delete();
        qw1.delete(); qs1.delete(); qg1.delete();
    endtask

    task automatic push_a(input logic [7:0] w, output int acc, output bit ok);
        int t = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && t < 200) begin @(posedge tx_clk); #2; t++; end
        ok  = s_ready;
        acc = -1;
        if (ok) begin @(posedge tx_clk); #2; acc = cyc; end
        s_valid = 1'b0;
    endtask

    task automatic push_g0(input logic [7:0] w, output int acc, output bit ok);
        int t = 0;
        g0_s_valid = 1'b1;
        g0_s_data  = w;
        while (!g0_s_ready && t < 200) begin @(posedge tx_clk); #2; t++; end
        ok  = g0_s_ready;
        acc = -1;
        if (ok) begin @(posedge tx_clk); #2; acc = cyc; end
        g0_s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int m, input int n, input int budget, output bit ok);
        int t = 0;
        ok = ((m == 0) ? qw0.size() : qw1.size()) >= n;
        while (!ok && t < budget) begin
            @(posedge tx_clk); #2; t++;
            ok = ((m == 0) ? qw0.size() : qw1.size()) >= n;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int t = 0;
        while ((busy || g0_busy) && t < 300) begin @(posedge tx_clk); #2; t++; end
        ok = !busy && !g0_busy;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge tx_clk); #2;
            checks++;
            if ({tx_p, tx_n, g0_tx_p, g0_tx_n} !== 4'b0000) begin
                errors++; $display("FAIL reset_lines: got %b required 0000", {tx_p, tx_n, g0_tx_p, g0_tx_n});
            end
        end
        checks++;
        if ({s_ready, busy, fifo_level} !== {1'b1, 1'b0, 3'd0}) begin
            errors++; $display("FAIL reset_status: ready=%b busy=%b level=%0d required 1 0 0", s_ready, busy, fifo_level);
        end
        @(negedge tx_clk); reset_n = 1'b1;
        repeat (6) @(posedge tx_clk);
        #2;
        checks++;
        if (pulses[0] + pulses[1] != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: pulses=%0d busy=%b required 0 0", pulses[0] + pulses[1], busy);
        end
    endtask

    task automatic test_single();
        int acc; bit ok; bit okf;
        clear_queues();
        push_a(8'hA5, acc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_accept: s_ready stayed 0"); end
        wait_frames(0, 1, 40, okf);
        checks++;
        if (!okf) begin
            errors++; $display("FAIL single_frame: no frame within 40 cycles");
        end else begin
            checks++;
            if (qw0[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h required a5", qw0[0]); end
            checks++;
            if (qs0[0] != acc + 2) begin errors++; $display("FAIL single_latency: start at %0d required %0d", qs0[0], acc + 2); end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_gap: got %b required 1", busy); end
            @(posedge tx_clk); #2;
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b required 0", busy); end
        end
    endtask

    task automatic test_gap0();
        int a0, a1; bit ok0, ok1, okf;
        clear_queues();
        push_g0(8'h00, a0, ok0);
        push_g0(8'hFF, a1, ok1);
        wait_frames(1, 2, 60, okf);
        checks++;
        if (!(ok0 && ok1 && okf)) begin
            errors++; $display("FAIL gap0_frames: accepted=%b%b frames=%0d required 2", ok0, ok1, qw1.size());
        end else begin
            checks++;
            if (qw1[0] !== 8'h00 || qw1[1] !== 8'hFF) begin
                errors++; $display("FAIL gap0_data: got %h %h required 00 ff", qw1[0], qw1[1]);
            end
            checks++;
            if (qg1[1] != 0 || qs1[1] != qs1[0] + 10) begin
                errors++; $display("FAIL gap0_contiguous: gap=%0d start delta=%0d required 0 10", qg1[1], qs1[1] - qs1[0]);
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [7:0] w [4];
        int acc; bit ok; bit okf; int p0;
        clear_queues();
        tx_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w[i] = 8'($urandom);
            push_a(w[i], acc, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL hold_push%0d: not accepted", i); end
        end
        p0 = pulses[0];
        s_valid = 1'b1;
        s_data  = 8'h3C;
        repeat (5) begin @(posedge tx_clk); #2; end
        checks++;
        if ({s_ready, fifo_level, busy} !== {1'b0, 3'd4, 1'b1}) begin
            errors++; $display("FAIL hold_full: ready=%b level=%0d busy=%b required 0 4 1", s_ready, fifo_level, busy);
        end
        checks++;
        if (pulses[0] != p0) begin errors++; $display("FAIL hold_quiet: pulses=%0d required 0", pulses[0] - p0); end
        s_valid   = 1'b0;
        tx_enable = 1'b1;
        wait_frames(0, 4, 80, okf);
        checks++;
        if (!okf) begin
            errors++; $display("FAIL hold_release: frames=%0d required 4", qw0.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (qw0[i] !== w[i]) begin errors++; $display("FAIL hold_data%0d: got %h required %h", i, qw0[i], w[i]); end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (qg0[i] != 1) begin errors++; $display("FAIL hold_gap%0d: got %0d required 1", i, qg0[i]); end
            end
        end
    endtask

    task automatic test_flush();
        logic [7:0] w [3];
        int acc; bit ok; bit okf; int t;
        clear_queues();
        tx_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w[i] = 8'($urandom);
            push_a(w[i], acc, ok);
        end
        checks++;
        if (fifo_level !== 3'd3) begin errors++; $display("FAIL flush_level_pre: got %0d required 3", fifo_level); end
        tx_enable = 1'b1;
        t = 0;
        while (in_frame[0] == 0 && t < 20) begin @(posedge tx_clk); #2; t++; end
        repeat (3) begin @(posedge tx_clk); #2; end
        flush = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b required 0", s_ready); end
        @(posedge tx_clk); #2;
        flush = 1'b0;
        checks++;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL flush_level: got %0d required 0", fifo_level); end
        wait_frames(0, 1, 30, okf);
        checks++;
        if (!okf || qw0[0] !== w[0]) begin
            errors++; $display("FAIL flush_inflight: frames=%0d word=%h required 1 %h", qw0.size(), okf ? qw0[0] : 8'h00, w[0]);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_gap: got %b required 1", busy); end
        @(posedge tx_clk); #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_end: got %b required 0", busy); end
        repeat (25) @(posedge tx_clk);
        #2;
        checks++;
        if (qw0.size() != 1) begin errors++; $display("FAIL flush_dropped: frames=%0d required 1", qw0.size()); end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] w;
        int acc; bit ok; bit okf; bit oki;
        clear_queues();
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge tx_clk); #2; end
            w = 8'($urandom);
            push_a(w, acc, ok);
            if (ok) exp_q.push_back(w);
        end
        wait_frames(0, 12, 300, okf);
        checks++;
        if (!okf || exp_q.size() != 12) begin
            errors++; $display("FAIL random_count: frames=%0d accepted=%0d required 12", qw0.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (qw0[i] !== exp_q[i]) begin errors++; $display("FAIL random_data%0d: got %h required %h", i, qw0[i], exp_q[i]); end
                if (i > 0) begin
                    checks++;
                    if (qg0[i] < 1) begin errors++; $display("FAIL random_gap%0d: got %0d required >=1", i, qg0[i]); end
                end
            end
        end
        wait_idle(oki);
        checks++;
        if (!oki || fifo_level !== 3'd0) begin errors++; $display("FAIL random_drain: busy=%b level=%0d required 0 0", busy, fifo_level); end
    endtask

    task automatic test_reset_mid();
        int acc; bit ok; bit okf; int t;
        clear_queues();
        push_a(8'h96, acc, ok);
        push_a(8'h69, acc, ok);
        t = 0;
        while (in_frame[0] == 0 && t < 20) begin @(posedge tx_clk); #2; t++; end
        repeat (3) begin @(posedge tx_clk); #2; end
        checks++;
        if ((tx_p | tx_n) !== 1'b1) begin errors++; $display("FAIL midreset_pre: no pulse mid-frame"); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({tx_p, tx_n, busy, fifo_level} !== 6'b0) begin
            errors++; $display("FAIL midreset_lines: p=%b n=%b busy=%b level=%0d required 0", tx_p, tx_n, busy, fifo_level);
        end
        @(negedge tx_clk); @(negedge tx_clk);
        reset_n = 1'b1;
        repeat (3) @(posedge tx_clk);
        #2;
        clear_queues();
        push_a(8'h3C, acc, ok);
        wait_frames(0, 1, 40, okf);
        checks++;
        if (!okf || qw0[0] !== 8'h3C || qs0[0] != acc + 2) begin
            errors++; $display("FAIL midreset_after: frames=%0d word=%h required 1 3c at %0d", qw0.size(), okf ? qw0[0] : 8'h00, acc + 2);
        end
    endtask

    task automatic test_protocol();
        bit oki;
        wait_idle(oki);
        checks++;
        if (!oki || frame_err != 0) begin errors++; $display("FAIL line_protocol: frame errors=%0d idle=%b required 0 1", frame_err, oki); end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_gap0();
        test_enable_hold();
        test_flush();
        test_random();
        test_reset_mid();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
